vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE_PIXEL_COUNT, default 1280: visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT_PORCH, default 110: pixels in the horizontal front porch.
REQ-003 The block SHALL have parameter H_SYNC_WIDTH, default 40: pixels in the hsync pulse.
REQ-004 The block SHALL have parameter H_BACK_PORCH, default 220: pixels in the horizontal back porch.
REQ-005 The block SHALL have parameter V_ACTIVE_LINE_COUNT, default 720: visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT_PORCH, default 5: lines in the vertical front porch.
REQ-007 The block SHALL have parameter V_SYNC_WIDTH, default 5: lines in the vsync pulse.
REQ-008 The block SHALL have parameter V_BACK_PORCH, default 20: lines in the vertical back porch.
REQ-009 The block SHALL have parameter SYNC_POS, default 1: 1 means sync pulses are active-high, 0 means active-low.
REQ-010 clk  input  1  pixel clock, 74.25 MHz for 720p; sole clock; all logic on the rising edge.
REQ-011 rst  input  1  asynchronous, active-high reset.
REQ-012 h_counter  output  12  pixel index within the line, 0..H_TOTAL-1.
REQ-013 v_counter  output  12  line index within the frame, 0..V_TOTAL-1.
REQ-014 hsync  output  1  horizontal sync at the polarity set by SYNC_POS.
REQ-015 vsync  output  1  vertical sync at the polarity set by SYNC_POS.
REQ-016 active  output  1  high while h_counter < H_ACTIVE_PIXEL_COUNT and v_counter < V_ACTIVE_LINE_COUNT.
REQ-017 line_start  output  1  one-cycle pulse while h_counter==0.
REQ-018 frame_start  output  1  one-cycle pulse while h_counter==0 and v_counter==0.
REQ-019 frame_count  output  16  number of completed frames since reset; wraps.

Function
REQ-020 H_TOTAL SHALL equal H_ACTIVE_PIXEL_COUNT+H_FRONT_PORCH+H_SYNC_WIDTH+H_BACK_PORCH (1650 by default); V_TOTAL SHALL be formed the same way from the vertical parameters (750 by default).
REQ-021 h_counter SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-022 v_counter SHALL increment by 1 on the clock where h_counter wraps, and SHALL wrap from V_TOTAL-1 to 0 when both counters are at their maxima.
REQ-023 A horizontal state machine SHALL track the line phase with states H_ACT, H_FP, H_SYNC and H_BP.
REQ-024 H_ACT SHALL go to H_FP when h_counter reaches H_ACTIVE_PIXEL_COUNT, and H_FP SHALL go to H_SYNC when h_counter reaches H_ACTIVE_PIXEL_COUNT+H_FRONT_PORCH.
REQ-025 H_SYNC SHALL go to H_BP when the sync width has elapsed, and H_BP SHALL go to H_ACT when h_counter wraps to 0.
REQ-026 A vertical state machine SHALL use the same four-phase scheme, advancing only on h_counter wrap.
REQ-027 hsync SHALL be asserted exactly while the horizontal state is H_SYNC, i.e. h_counter in [1390,1429] by default.
REQ-028 vsync SHALL be asserted exactly while the vertical state is V_SYNC, i.e. v_counter in [725,729] by default, for whole lines from h_counter 0.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-030 active, line_start and frame_start SHALL be cycle-aligned with h_counter and v_counter (zero relative latency when the delay feature is off).
REQ-031 frame_count SHALL increment on the clock where v_counter wraps to 0, and SHALL wrap from 65535 to 0.

Reset
REQ-032 While rst is high, h_counter, v_counter and frame_count SHALL be 0, active SHALL be 0, line_start and frame_start SHALL be 0, hsync and vsync SHALL be at their inactive level, and both state machines SHALL be in H_ACT/V_ACT.
REQ-033 On the first rising clk edge after rst deasserts, counters SHALL remain at 0 and frame_start, line_start and active SHALL be 1; counting SHALL resume on the following edge.
REQ-034 Reset asserted mid-line or mid-frame SHALL take effect immediately (asynchronously) with no partial-line completion.

Configuration
REQ-035 The feature SHALL be controlled by macro VGA_SYNC_DELAY_EN, which adds sync alignment for a synchronous-ROM pixel path.
REQ-036 With VGA_SYNC_DELAY_EN defined, hsync, vsync and active SHALL be delayed by 2 clocks relative to h_counter/v_counter through a shift register reset to the inactive level, to match the 2-cycle ROM latency downstream.
REQ-037 Without VGA_SYNC_DELAY_EN defined, no delay registers SHALL exist and REQ-030 SHALL apply to all outputs.

Structure
REQ-038 A shared package vga_timing_pkg SHALL hold the default 720p timing constants, the H_TOTAL and V_TOTAL derivation, and the enum for the four-phase state type used by both axes.
REQ-039 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal and vertical); it SHALL take a count enable and the four phase lengths, and produce count, phase, wrap and sync.

Verification
REQ-040 Release reset and run 1650 clocks -> h_counter reads 0..1649 and then 0, v_counter steps 0->1, and line_start pulses at clocks 1 and 1651.
REQ-041 Run one full frame of 1,237,500 clocks -> exactly 5 vsync lines, 750 hsync pulses of 40 clocks each, 921,600 active cycles, and frame_count 0->1.
REQ-042 Assert rst at h_counter=800, v_counter=300 -> all outputs reach their reset values without waiting for a clk edge.
REQ-043 Build with SYNC_POS=0 -> hsync is low only for h_counter 1390..1429 and high otherwise, including during reset.
REQ-044 Build with VGA_SYNC_DELAY_EN defined -> the hsync rising edge occurs 2 clocks after h_counter==1390 and active falls 2 clocks after h_counter==1280.
REQ-045 Force frame_count to 65535 and complete a frame -> frame_count wraps to 0 on the same clock that frame_start is asserted.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 720p timing defaults, the per-axis total derivation and the
//   four-phase type used by both the horizontal and the vertical axis.
package vga_timing_pkg;

  // Width of the h/v pixel and line counters.
  localparam int unsigned CNT_W = 12;

  // Default 1280x720 @ 60 Hz timing.
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  // Period of one axis: active region plus both porches plus the sync pulse.
  function automatic int unsigned axis_total(input int unsigned active_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);  // 1650
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);  // 750

  // Phase of a line (H_ACT/H_FP/H_SYNC/H_BP) or of a frame (V_ACT/...).
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis: a wrapping counter plus a four-phase state machine
//   (active, front porch, sync, back porch). Instantiated once per axis.
// Ports:
//   clk, rst  pixel clock, asynchronous active-high reset
//   en        advance the counter by one on this clock
//   count     registered position within the axis, 0..total-1
//   phase     registered phase of the current count
//   wrap      high on the clock where count goes from total-1 to 0
//   sync      registered sync pulse at SYNC_POS polarity, asserted in PH_SYNC
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int unsigned FP_LEN     = DEF_H_FP,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter int unsigned BP_LEN     = DEF_H_BP,
  parameter bit          SYNC_POS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic             wrap,
  output logic             sync
);

  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE_LEN + FP_LEN);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
  localparam logic [CNT_W-1:0] LAST       =
    CNT_W'(axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN) - 1);

  logic [CNT_W-1:0] count_next;
  phase_t           phase_next;

  assign wrap = en && (count == LAST);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (en) count_next = wrap ? '0 : count + CNT_W'(1);
  end

  // The phase register is loaded from the count it is about to hold, so
  // phase and sync are aligned with count rather than one clock behind.
  always_comb begin
    phase_next = phase;
    if (count_next == '0)              phase_next = PH_ACT;
    else if (count_next == FP_START)   phase_next = PH_FP;
    else if (count_next == SYNC_START) phase_next = PH_SYNC;
    else if (count_next == BP_START)   phase_next = PH_BP;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= PH_ACT;
      sync  <= ~SYNC_POS;
    end else begin
      count <= count_next;
      phase <= phase_next;
      sync  <= (phase_next == PH_SYNC) ? SYNC_POS : ~SYNC_POS;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Video timing generator (720p defaults): pixel/line counters, sync pulses,
//   active-video flag, line/frame start strobes and a frame counter.
//   Every output comes straight from a register.
// Build option:
//   VGA_SYNC_DELAY_EN  delay hsync, vsync and active by 2 clocks relative to
//                      h_counter/v_counter, to line up with a 2-cycle
//                      synchronous pixel ROM downstream.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   h_counter    pixel index within the line
//   v_counter    line index within the frame
//   hsync/vsync  sync pulses at the polarity set by SYNC_POS
//   active       visible-region flag
//   line_start   high while h_counter == 0
//   frame_start  high while h_counter == 0 and v_counter == 0
//   frame_count  completed frames since reset, wrapping
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE_PIXEL_COUNT = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT_PORCH        = DEF_H_FP,
  parameter int unsigned H_SYNC_WIDTH         = DEF_H_SYNC,
  parameter int unsigned H_BACK_PORCH         = DEF_H_BP,
  parameter int unsigned V_ACTIVE_LINE_COUNT  = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT_PORCH        = DEF_V_FP,
  parameter int unsigned V_SYNC_WIDTH         = DEF_V_SYNC,
  parameter int unsigned V_BACK_PORCH         = DEF_V_BP,
  parameter bit          SYNC_POS             = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_counter,
  output logic [CNT_W-1:0] v_counter,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE_PIXEL_COUNT - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE_LINE_COUNT - 1);

  // Low from reset until the first clock after release: that clock presents
  // position (0,0) with its strobes, and counting starts on the next one.
  logic   run;
  logic   h_wrap, v_wrap;
  logic   h_sync_raw, v_sync_raw;
  phase_t h_phase, v_phase;
  logic   h_act_next, v_act_next;
  logic   active_raw;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE_PIXEL_COUNT),
    .FP_LEN     (H_FRONT_PORCH),
    .SYNC_LEN   (H_SYNC_WIDTH),
    .BP_LEN     (H_BACK_PORCH),
    .SYNC_POS   (SYNC_POS)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .count (h_counter),
    .phase (h_phase),
    .wrap  (h_wrap),
    .sync  (h_sync_raw)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE_LINE_COUNT),
    .FP_LEN     (V_FRONT_PORCH),
    .SYNC_LEN   (V_SYNC_WIDTH),
    .BP_LEN     (V_BACK_PORCH),
    .SYNC_POS   (SYNC_POS)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (v_counter),
    .phase (v_phase),
    .wrap  (v_wrap),
    .sync  (v_sync_raw)
  );

  // Whether each axis will be in its active region after this edge, derived
  // from the current phase and whether the counter is about to step out.
  always_comb begin
    h_act_next = !run || h_wrap ||
                 ((h_phase == PH_ACT) && (h_counter != H_ACT_LAST));
    v_act_next = v_wrap ||
                 ((v_phase == PH_ACT) && !(h_wrap && (v_counter == V_ACT_LAST)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      active_raw  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      run         <= 1'b1;
      active_raw  <= h_act_next && v_act_next;
      line_start  <= !run || h_wrap;
      frame_start <= !run || v_wrap;
      if (v_wrap) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Two-stage delay line, bit 1 is the output end.
  logic [1:0] hsync_dly, vsync_dly, active_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_dly  <= {2{~SYNC_POS}};
      vsync_dly  <= {2{~SYNC_POS}};
      active_dly <= 2'b00;
    end else begin
      hsync_dly  <= {hsync_dly[0], h_sync_raw};
      vsync_dly  <= {vsync_dly[0], v_sync_raw};
      active_dly <= {active_dly[0], active_raw};
    end
  end

  assign hsync  = hsync_dly[1];
  assign vsync  = vsync_dly[1];
  assign active = active_dly[1];
`else
  assign hsync  = h_sync_raw;
  assign vsync  = v_sync_raw;
  assign active = active_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen on a reduced raster (17 x 8) so whole
//   frames fit in a few hundred clocks. A second instance is built with
//   active-low sync. A small reference model tracks the expected position.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;  // 17
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;  // 8
  localparam int FRAME = HT * VT;                                         // 136

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] h_counter, v_counter, n_h_counter, n_v_counter;
  logic        hsync, vsync, active, line_start, frame_start;
  logic        n_hsync, n_vsync, n_active, n_line_start, n_frame_start;
  logic [15:0] frame_count, n_frame_count;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen #(
    .H_ACTIVE_PIXEL_COUNT(HA), .H_FRONT_PORCH(HF), .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HB),
    .V_ACTIVE_LINE_COUNT(VA), .V_FRONT_PORCH(VF), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VB),
    .SYNC_POS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
    .hsync(hsync), .vsync(vsync), .active(active), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_ACTIVE_PIXEL_COUNT(HA), .H_FRONT_PORCH(HF), .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HB),
    .V_ACTIVE_LINE_COUNT(VA), .V_FRONT_PORCH(VF), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VB),
    .SYNC_POS(1'b0)
  ) dut_neg (
    .clk(clk), .rst(rst), .h_counter(n_h_counter), .v_counter(n_v_counter),
    .hsync(n_hsync), .vsync(n_vsync), .active(n_active), .line_start(n_line_start),
    .frame_start(n_frame_start), .frame_count(n_frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: position after each edge, plus a short history of the
  // undelayed active/sync levels so the delayed build can be predicted too.
  int          m_h, m_v;
  logic [15:0] m_frame;
  bit          m_run;
  bit [2:0]    act_h, hs_h, vs_h;
  bit          e_act, e_hs, e_vs;

  task automatic model_reset();
    m_run = 0; m_h = 0; m_v = 0; m_frame = 16'd0;
    act_h = 3'b000; hs_h = 3'b000; vs_h = 3'b000;
    e_act = 0; e_hs = 0; e_vs = 0;
  endtask

  // Advance one clock, update the model, then move to the sampling point.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!m_run) m_run = 1;
      else if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin m_v = 0; m_frame = m_frame + 16'd1; end
        else m_v = m_v + 1;
      end else m_h = m_h + 1;
      act_h = {act_h[1:0], (m_h < HA) && (m_v < VA)};
      hs_h  = {hs_h[1:0], (m_h >= HA + HF) && (m_h < HA + HF + HS)};
      vs_h  = {vs_h[1:0], (m_v >= VA + VF) && (m_v < VA + VF + VS)};
    end
`ifdef VGA_SYNC_DELAY_EN
    e_act = act_h[2]; e_hs = hs_h[2]; e_vs = vs_h[2];
`else
    e_act = act_h[0]; e_hs = hs_h[0]; e_vs = vs_h[0];
`endif
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (h_counter !== 12'd0)    begin n_err++; $display("FAIL reset_h_counter: got %0d want 0", h_counter); end
    n_cmp++; if (v_counter !== 12'd0)    begin n_err++; $display("FAIL reset_v_counter: got %0d want 0", v_counter); end
    n_cmp++; if (frame_count !== 16'd0)  begin n_err++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (active !== 1'b0)        begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (line_start !== 1'b0)    begin n_err++; $display("FAIL reset_line_start: got %b want 0", line_start); end
    n_cmp++; if (frame_start !== 1'b0)   begin n_err++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    n_cmp++; if (hsync !== 1'b0)         begin n_err++; $display("FAIL reset_hsync: got %b want 0", hsync); end
    n_cmp++; if (vsync !== 1'b0)         begin n_err++; $display("FAIL reset_vsync: got %b want 0", vsync); end
    n_cmp++; if (n_hsync !== 1'b1)       begin n_err++; $display("FAIL reset_hsync_neg: got %b want 1", n_hsync); end
    n_cmp++; if (n_vsync !== 1'b1)       begin n_err++; $display("FAIL reset_vsync_neg: got %b want 1", n_vsync); end
    tick(); tick();
    n_cmp++; if (h_counter !== 12'd0)    begin n_err++; $display("FAIL reset_hold_h_counter: got %0d want 0", h_counter); end
    n_cmp++; if (line_start !== 1'b0)    begin n_err++; $display("FAIL reset_hold_line_start: got %b want 0", line_start); end
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (h_counter !== 12'd0)    begin n_err++; $display("FAIL first_h_counter: got %0d want 0", h_counter); end
    n_cmp++; if (v_counter !== 12'd0)    begin n_err++; $display("FAIL first_v_counter: got %0d want 0", v_counter); end
    n_cmp++; if (line_start !== 1'b1)    begin n_err++; $display("FAIL first_line_start: got %b want 1", line_start); end
    n_cmp++; if (frame_start !== 1'b1)   begin n_err++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
    n_cmp++; if (active !== e_act)       begin n_err++; $display("FAIL first_active: got %b want %b", active, e_act); end
    tick();
    n_cmp++; if (h_counter !== 12'd1)    begin n_err++; $display("FAIL second_h_counter: got %0d want 1", h_counter); end
    n_cmp++; if (line_start !== 1'b0)    begin n_err++; $display("FAIL second_line_start: got %b want 0", line_start); end
    n_cmp++; if (frame_start !== 1'b0)   begin n_err++; $display("FAIL second_frame_start: got %b want 0", frame_start); end
  endtask

  // One full line: h runs up to HT-1, wraps, v steps 0 -> 1.
  task automatic test_line();
    for (int i = 0; i < HT; i++) begin
      tick();
      n_cmp++; if (h_counter !== 12'(m_h)) begin n_err++; $display("FAIL line_h_counter: got %0d want %0d", h_counter, m_h); end
      n_cmp++; if (line_start !== (m_h == 0)) begin n_err++; $display("FAIL line_start_pulse: got %b want %b at h %0d", line_start, (m_h == 0), m_h); end
    end
    n_cmp++; if (h_counter !== 12'd1 || v_counter !== 12'd1) begin n_err++; $display("FAIL line_end_pos: got h %0d v %0d want h 1 v 1", h_counter, v_counter); end
  endtask

  // Two whole frames checked cycle by cycle; pulse statistics over one frame.
  task automatic test_full_frame();
    int act_cnt = 0, hs_hi = 0, hs_rise = 0, vs_hi = 0;
    logic hs_prev;
    hs_prev = hsync;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_cmp++; if (h_counter !== 12'(m_h) || v_counter !== 12'(m_v)) begin n_err++; $display("FAIL frame_pos: got h %0d v %0d want h %0d v %0d", h_counter, v_counter, m_h, m_v); end
      n_cmp++; if (active !== e_act) begin n_err++; $display("FAIL frame_active: got %b want %b at h %0d v %0d", active, e_act, m_h, m_v); end
      n_cmp++; if (hsync !== e_hs || vsync !== e_vs) begin n_err++; $display("FAIL frame_sync: got hs %b vs %b want hs %b vs %b at h %0d v %0d", hsync, vsync, e_hs, e_vs, m_h, m_v); end
      n_cmp++; if (n_hsync !== !e_hs || n_vsync !== !e_vs) begin n_err++; $display("FAIL frame_sync_neg: got hs %b vs %b want hs %b vs %b at h %0d v %0d", n_hsync, n_vsync, !e_hs, !e_vs, m_h, m_v); end
      n_cmp++; if (line_start !== (m_h == 0) || frame_start !== (m_h == 0 && m_v == 0)) begin n_err++; $display("FAIL frame_strobes: got ls %b fs %b at h %0d v %0d", line_start, frame_start, m_h, m_v); end
      n_cmp++; if (frame_count !== m_frame) begin n_err++; $display("FAIL frame_count: got %0d want %0d", frame_count, m_frame); end
      n_cmp++; if (n_h_counter !== 12'(m_h) || n_v_counter !== 12'(m_v) || n_active !== e_act || n_line_start !== line_start || n_frame_start !== frame_start || n_frame_count !== m_frame)
        begin n_err++; $display("FAIL frame_neg_misc: got h %0d v %0d act %b fc %0d", n_h_counter, n_v_counter, n_active, n_frame_count); end
      if (i < FRAME) begin
        act_cnt += int'(active);
        hs_hi   += int'(hsync);
        vs_hi   += int'(vsync);
        if (hsync && !hs_prev) hs_rise++;
      end
      hs_prev = hsync;
    end
    n_cmp++; if (act_cnt != HA * VA)  begin n_err++; $display("FAIL frame_active_cycles: got %0d want %0d", act_cnt, HA * VA); end
    n_cmp++; if (hs_hi != HS * VT)    begin n_err++; $display("FAIL frame_hsync_cycles: got %0d want %0d", hs_hi, HS * VT); end
    n_cmp++; if (hs_rise != VT)       begin n_err++; $display("FAIL frame_hsync_pulses: got %0d want %0d", hs_rise, VT); end
    n_cmp++; if (vs_hi != VS * HT)    begin n_err++; $display("FAIL frame_vsync_cycles: got %0d want %0d", vs_hi, VS * HT); end
    n_cmp++; if (frame_count !== 16'd2) begin n_err++; $display("FAIL frame_count_after: got %0d want 2", frame_count); end
  endtask

  // Reset in the middle of an hsync pulse must clear everything at once.
  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (m_h == HA + HF + 2 && m_v == 2) found = 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL mid_reset_reach: got timeout want h %0d v 2", HA + HF + 2); end
    n_cmp++; if (hsync !== 1'b1 || frame_count !== 16'd2) begin n_err++; $display("FAIL mid_reset_before: got hs %b fc %0d want hs 1 fc 2", hsync, frame_count); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (h_counter !== 12'd0 || v_counter !== 12'd0) begin n_err++; $display("FAIL mid_reset_counters: got h %0d v %0d want 0 0", h_counter, v_counter); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL mid_reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (hsync !== 1'b0 || vsync !== 1'b0) begin n_err++; $display("FAIL mid_reset_sync: got hs %b vs %b want 0 0", hsync, vsync); end
    n_cmp++; if (n_hsync !== 1'b1 || n_vsync !== 1'b1) begin n_err++; $display("FAIL mid_reset_sync_neg: got hs %b vs %b want 1 1", n_hsync, n_vsync); end
    n_cmp++; if (active !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags: got act %b ls %b fs %b want 0 0 0", active, line_start, frame_start); end
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // frame_count wraps 65535 -> 0 together with frame_start.
  task automatic test_frame_wrap();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      tick();
      if (m_v == VT - 1 && m_h == HT - 4) found = 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL wrap_reach: got timeout want h %0d v %0d", HT - 4, VT - 1); end
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    m_frame = 16'hFFFF;
    tick(); tick(); tick();
    n_cmp++; if (frame_count !== 16'hFFFF || frame_start !== 1'b0) begin n_err++; $display("FAIL wrap_before: got fc %0d fs %b want 65535 0", frame_count, frame_start); end
    tick();
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL wrap_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (frame_start !== 1'b1 || v_counter !== 12'd0 || h_counter !== 12'd0) begin n_err++; $display("FAIL wrap_frame_start: got fs %b h %0d v %0d want 1 0 0", frame_start, h_counter, v_counter); end
    tick();
    n_cmp++; if (frame_count !== 16'd0 || frame_start !== 1'b0) begin n_err++; $display("FAIL wrap_after: got fc %0d fs %b want 0 0", frame_count, frame_start); end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_first_edge();
    test_line();
    test_full_frame();
    test_mid_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
